// File: rtl/boot_rom_tcdm_adapter.sv
// ---------------------------------------------------------------------------
// boot_rom_tcdm_adapter
//
// Bridges a TCDM-style slave request (req/gnt with a fixed one-cycle r_valid
// response) onto the boot ROM macro's chip-select / word-address interface.
// Writes and accesses outside the ROM window get an error response without
// touching the ROM. A one-word last-read buffer answers repeated fetches of
// the same word (boot polling loops) without re-enabling the ROM.
//
// Ports
//   clk_i        clock
//   rst_ni       synchronous active-low reset
//   init_ni      low = ROM not usable yet: no grants, buffer invalidated
//   test_mode_i  reserved, no functional effect
//   req_i        request valid
//   add_i        byte offset into the ROM window
//   wen_i        1 = read, 0 = write
//   be_i         byte enables (ignored)
//   wdata_i      write data (ignored)
//   gnt_o        request accepted this cycle (combinational)
//   r_valid_o    response valid, one cycle after each grant
//   r_rdata_o    response data
//   r_opc_o      1 = error response
//   rom_csn_o    ROM chip select, active low
//   rom_addr_o   ROM word address
//   rom_q_i      ROM read data, valid the cycle after rom_csn_o was low
// ---------------------------------------------------------------------------
module boot_rom_tcdm_adapter #(
    parameter int unsigned ROM_ADDR_WIDTH = 13,
    parameter logic [31:0] ERR_RDATA      = 32'hBADACCE5,
    parameter bit          BUF_EN         = 1'b1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      init_ni,
    input  logic                      test_mode_i,
    input  logic                      req_i,
    input  logic [31:0]               add_i,
    input  logic                      wen_i,
    input  logic [3:0]                be_i,
    input  logic [31:0]               wdata_i,
    output logic                      gnt_o,
    output logic                      r_valid_o,
    output logic [31:0]               r_rdata_o,
    output logic                      r_opc_o,
    output logic                      rom_csn_o,
    output logic [ROM_ADDR_WIDTH-3:0] rom_addr_o,
    input  logic [31:0]               rom_q_i
);

    localparam int unsigned WORD_AW = ROM_ADDR_WIDTH - 2;

    // Where the response of the previous cycle's grant comes from.
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_MISS = 2'd1,
        SRC_HIT  = 2'd2,
        SRC_ERR  = 2'd3
    } resp_src_e;

    resp_src_e          resp_src_reg, resp_src_next;
    logic               buf_valid_reg, buf_valid_next;
    logic [WORD_AW-1:0] buf_tag_reg, buf_tag_next;
    logic [31:0]        buf_data_reg, buf_data_next;

    logic [WORD_AW-1:0] word_addr;
    logic               gnt;
    logic               is_err;
    logic               is_hit;
    logic               rom_read;

    // Byte lanes, write data, sub-word offset and test mode carry no meaning
    // for a word-only read-only memory.
    logic unused_inputs;
    assign unused_inputs = ^{test_mode_i, be_i, wdata_i, add_i[1:0]};

    assign word_addr = add_i[ROM_ADDR_WIDTH-1:2];
    assign gnt       = req_i & init_ni & rst_ni;
    assign is_err    = ~wen_i | (|add_i[31:ROM_ADDR_WIDTH]);
    assign is_hit    = BUF_EN && buf_valid_reg && (buf_tag_reg == word_addr);
    assign rom_read  = gnt & ~is_err & ~is_hit;

    assign gnt_o      = gnt;
    assign rom_csn_o  = ~rom_read;
    assign rom_addr_o = word_addr;

    always_comb begin
        resp_src_next  = SRC_NONE;
        buf_valid_next = buf_valid_reg;
        buf_tag_next   = buf_tag_reg;
        buf_data_next  = buf_data_reg;

        if (gnt) begin
            if (is_err) begin
                resp_src_next = SRC_ERR;
            end else if (is_hit) begin
                resp_src_next = SRC_HIT;
            end else begin
                resp_src_next = SRC_MISS;
            end
        end

        // The tag is claimed at grant while the data only lands one cycle
        // later; a hit on a word whose miss is still in its response cycle
        // therefore reads buf_data_reg after this capture, which is exactly
        // the word the ROM is delivering now.
        if (!init_ni) begin
            buf_valid_next = 1'b0;
        end else if (rom_read) begin
            buf_valid_next = 1'b1;
            buf_tag_next   = word_addr;
        end

        if (resp_src_reg == SRC_MISS) begin
            buf_data_next = rom_q_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            resp_src_reg  <= SRC_NONE;
            buf_valid_reg <= 1'b0;
            buf_tag_reg   <= '0;
            buf_data_reg  <= '0;
        end else begin
            resp_src_reg  <= resp_src_next;
            buf_valid_reg <= buf_valid_next;
            buf_tag_reg   <= buf_tag_next;
            buf_data_reg  <= buf_data_next;
        end
    end

    // Response mux: a miss passes the ROM output straight through so no
    // extra cycle of latency is added.
    always_comb begin
        r_valid_o = 1'b0;
        r_opc_o   = 1'b0;
        r_rdata_o = '0;
        case (resp_src_reg)
            SRC_MISS: begin
                r_valid_o = 1'b1;
                r_rdata_o = rom_q_i;
            end
            SRC_HIT: begin
                r_valid_o = 1'b1;
                r_rdata_o = buf_data_reg;
            end
            SRC_ERR: begin
                r_valid_o = 1'b1;
                r_opc_o   = 1'b1;
                r_rdata_o = ERR_RDATA;
            end
            default: begin
                r_valid_o = 1'b0;
            end
        endcase
    end

endmodule
